// File: rtl/finish_gen_mc.sv
// finish_gen_mc: multi-channel beat counter / finish flag generator.
//
// Each of NUM_CH channels counts qualified beats (enable && cnt_enable[i]) up to a
// per-channel target latched on start, then reports completion on finish[i], either
// as a sticky level or as a single-cycle pulse (mode latched on start).
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   enable      global count gate; low pauses every counter
//   clear       synchronous return of all channels to IDLE
//   start       one-cycle job start for all channels; latches targets and mode
//   pulse_mode  0 = level finish, 1 = pulse finish; sampled only on start
//   cnt_enable  per-channel beat qualifier
//   total_num   per-channel target, channel i at [i*CNT_W +: CNT_W]
//   finish      per-channel completion flag (registered)
//   all_finish  all channels complete (registered)
//   busy        any channel counting (registered)
//   count_out   live per-channel beat count (registered)
module finish_gen_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    pulse_mode,
  input  logic [NUM_CH-1:0]       cnt_enable,
  input  logic [NUM_CH*CNT_W-1:0] total_num,
  output logic [NUM_CH-1:0]       finish,
  output logic                    all_finish,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] count_out
);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero = '0;

  state_e                         state_q [NUM_CH];
  state_e                         state_d [NUM_CH];
  logic   [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic   [NUM_CH-1:0][CNT_W-1:0] tgt_q, tgt_d;
  logic   [NUM_CH-1:0]            mode_q, mode_d;
  logic   [NUM_CH-1:0]            finish_q, finish_d;
  logic                           all_finish_q, all_finish_d;
  logic                           busy_q, busy_d;

  // entry: channel moves into DONE on this edge (final beat or zero-length start).
  // stay:  channel was in DONE and nothing disturbs it this edge.
  logic   [NUM_CH-1:0]            entry;
  logic   [NUM_CH-1:0]            stay;
  logic   [NUM_CH-1:0]            done_d;
  logic   [NUM_CH-1:0]            count_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tgt_d[i]   = tgt_q[i];
      mode_d[i]  = mode_q[i];
      entry[i]   = 1'b0;
      stay[i]    = 1'b0;

      if (clear) begin
        // Clear beats start and any final beat in the same cycle.
        state_d[i] = StIdle;
        cnt_d[i]   = CntZero;
      end else if (start) begin
        // Start from any state restarts; a coincident final beat is dropped.
        tgt_d[i]  = total_num[i*CNT_W +: CNT_W];
        mode_d[i] = pulse_mode;
        cnt_d[i]  = CntZero;
        if (total_num[i*CNT_W +: CNT_W] == CntZero) begin
          state_d[i] = StDone;
          entry[i]   = 1'b1;
        end else begin
          state_d[i] = StCount;
        end
      end else begin
        unique case (state_q[i])
          StCount: begin
            if (enable && cnt_enable[i]) begin
              // cnt_q < tgt_q in COUNT, so the increment cannot wrap.
              cnt_d[i] = cnt_q[i] + CntOne;
              if (cnt_q[i] + CntOne == tgt_q[i]) begin
                state_d[i] = StDone;
                entry[i]   = 1'b1;
              end
            end
          end
          StDone: begin
            stay[i] = 1'b1;
          end
          default: begin
            state_d[i] = StIdle;
          end
        endcase
      end

      finish_d[i] = entry[i] | (stay[i] & ~mode_q[i]);
      done_d[i]   = (state_d[i] == StDone);
      count_d[i]  = (state_d[i] == StCount);
    end

    // Channel 0's mode stands for all: start is common, so every channel shares it.
    if (mode_d[0]) begin
      all_finish_d = (&done_d) & (|entry);
    end else begin
      all_finish_d = &done_d;
    end
    busy_d = |count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
      end
      cnt_q        <= '0;
      tgt_q        <= '0;
      mode_q       <= '0;
      finish_q     <= '0;
      all_finish_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      mode_q       <= mode_d;
      finish_q     <= finish_d;
      all_finish_q <= all_finish_d;
      busy_q       <= busy_d;
    end
  end

  assign finish     = finish_q;
  assign all_finish = all_finish_q;
  assign busy       = busy_q;
  assign count_out  = cnt_q;

endmodule
